// File: rtl/rst_seq_pkg.sv
// Shared encodings for the reset sequencer: FSM states, reset-cause codes
// and a helper that sizes counters so they can hold their terminal value.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    // Width needed to hold 0..max_val inclusive (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// STAGES-deep synchronizer. arst_n clears the whole chain immediately;
// after arst_n rises the d value needs STAGES clock edges to reach q.
// With d tied high this is the classic async-assert/sync-deassert reset
// synchronizer; with a signal on d it is a plain metastability chain.
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the input one stage deeper each edge.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // Chain flops, cleared asynchronously.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes the board reset and a glitch-prone external
// reset, holds every channel in reset for HOLD_CYCLES, then releases the
// channels one at a time GAP_CYCLES apart and reports the last reset cause.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int STAGES      = 2,
    parameter int CHANNELS    = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int FILTER_LEN  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ext_rst_n,
    input  logic                sw_rst_req,
    output logic [CHANNELS-1:0] sync_rst_n,
    output logic                rst_done,
    output logic [1:0]          rst_cause
);

    localparam int HOLD_W = cnt_w(HOLD_CYCLES);
    localparam int GAP_W  = cnt_w(GAP_CYCLES);
    localparam int FILT_W = cnt_w(FILTER_LEN);
    localparam int CH_W   = cnt_w(CHANNELS);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);

    logic por_n;
    logic ext_sync_n;

    // Power-on reset: asserts with rst, releases STAGES edges after rst rises.
    rst_sync_chain #(.STAGES(STAGES)) u_por_sync (
        .clk    (clk),
        .arst_n (rst),
        .d      (1'b1),
        .q      (por_n)
    );

    // External reset is carried on the data path so a short glitch is not
    // stretched by the chain before the filter has a chance to reject it.
    rst_sync_chain #(.STAGES(STAGES)) u_ext_sync (
        .clk    (clk),
        .arst_n (rst),
        .d      (ext_rst_n),
        .q      (ext_sync_n)
    );

    logic [FILT_W-1:0]   filt_cnt_q, filt_cnt_d;
    logic                ext_trig;
    logic                sw_trig;
    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
    logic [CHANNELS-1:0] sync_rst_n_q, sync_rst_n_d;
    logic                rst_done_q, rst_done_d;
    logic [1:0]          rst_cause_q, rst_cause_d;

    // Glitch filter: the trigger fires on the FILTER_LEN-th consecutive low
    // sample and stays active while the input stays low.
    always_comb begin
        filt_cnt_d = filt_cnt_q;
        ext_trig   = 1'b0;
        if (ext_sync_n) begin
            filt_cnt_d = '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            ext_trig = 1'b1;
        end else begin
            filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    // Sequencer next state: triggers win over everything, then hold/release.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        ch_idx_d     = ch_idx_q;
        sync_rst_n_d = sync_rst_n_q;
        rst_done_d   = rst_done_q;
        rst_cause_d  = rst_cause_q;
        sw_trig      = sw_rst_req && (state_q != ST_HOLD);

        if (ext_trig) begin
            rst_cause_d = CAUSE_EXT;
        end else if (sw_trig) begin
            rst_cause_d = CAUSE_SW;
        end

        if (ext_trig || sw_trig) begin
            state_d      = ST_HOLD;
            hold_cnt_d   = '0;
            gap_cnt_d    = '0;
            ch_idx_d     = '0;
            sync_rst_n_d = '0;
            rst_done_d   = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d      = '0;
                        gap_cnt_d       = '0;
                        ch_idx_d        = CH_W'(1);
                        sync_rst_n_d[0] = 1'b1;
                        if (CHANNELS == 1) begin
                            state_d    = ST_RUN;
                            rst_done_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        ch_idx_d  = ch_idx_q + 1'b1;
                        for (int i = 0; i < CHANNELS; i++) begin
                            if (ch_idx_q == CH_W'(i)) begin
                                sync_rst_n_d[i] = 1'b1;
                            end
                        end
                        if (ch_idx_q == CH_LAST) begin
                            state_d    = ST_RUN;
                            rst_done_d = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    // Sequencer and filter state; the power-on reset overrides asynchronously.
    always_ff @(posedge clk or negedge por_n) begin
        if (!por_n) begin
            filt_cnt_q   <= '0;
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            ch_idx_q     <= '0;
            sync_rst_n_q <= '0;
            rst_done_q   <= 1'b0;
            rst_cause_q  <= CAUSE_POR;
        end else begin
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            ch_idx_q     <= ch_idx_d;
            sync_rst_n_q <= sync_rst_n_d;
            rst_done_q   <= rst_done_d;
            rst_cause_q  <= rst_cause_d;
        end
    end

    assign sync_rst_n = sync_rst_n_q;
    assign rst_done   = rst_done_q;
    assign rst_cause  = rst_cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with STAGES=2, CHANNELS=3, HOLD_CYCLES=4,
// GAP_CYCLES=2, FILTER_LEN=3. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point, so each check reflects the edge
// just taken.
module tb_rst_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       ext_rst_n;
    logic       sw_rst_req;
    logic [2:0] sync_rst_n;
    logic       rst_done;
    logic [1:0] rst_cause;

    int total = 0;
    int bad   = 0;

    rst_seq_ctrl #(
        .STAGES      (2),
        .CHANNELS    (3),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .FILTER_LEN  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ext_rst_n  (ext_rst_n),
        .sw_rst_req (sw_rst_req),
        .sync_rst_n (sync_rst_n),
        .rst_done   (rst_done),
        .rst_cause  (rst_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] e_srn,
                       input logic e_done, input logic [1:0] e_cause);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {sync_rst_n, rst_done, rst_cause};
        exp = {e_srn, e_done, e_cause};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed srn=%b done=%b cause=%b, expected srn=%b done=%b cause=%b",
                   tag, obs[5:3], obs[2], obs[1:0], exp[5:3], exp[2], exp[1:0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        ext_rst_n  = 1'b1;
        sw_rst_req = 1'b0;

        // Reset state
        step(2);             chk("reset_state",  3'b000, 1'b0, 2'b00);

        // Power-on release: T0 is the 2nd edge after rst rises
        rst = 1'b1;
        step(2);             chk("por_t0",       3'b000, 1'b0, 2'b00);
        step(3);             chk("por_t0p3",     3'b000, 1'b0, 2'b00);
        step(1);             chk("por_ch0",      3'b001, 1'b0, 2'b00);
        step(1);             chk("por_t0p5",     3'b001, 1'b0, 2'b00);
        step(1);             chk("por_ch1",      3'b011, 1'b0, 2'b00);
        step(1);             chk("por_t0p7",     3'b011, 1'b0, 2'b00);
        step(1);             chk("por_run",      3'b111, 1'b1, 2'b00);
        step(3);             chk("por_idle",     3'b111, 1'b1, 2'b00);

        // Two-cycle external glitch is ignored
        ext_rst_n = 1'b0;
        step(2);
        ext_rst_n = 1'b1;
        step(3);             chk("glitch2_a",    3'b111, 1'b1, 2'b00);
        step(3);             chk("glitch2_b",    3'b111, 1'b1, 2'b00);

        // Three-cycle external low triggers on the 5th edge (2 sync + 3 filter)
        ext_rst_n = 1'b0;
        step(3);
        ext_rst_n = 1'b1;
        step(1);             chk("ext3_pre",     3'b111, 1'b1, 2'b00);
        step(1);             chk("ext3_trig",    3'b000, 1'b0, 2'b01);
        step(3);             chk("ext3_hold",    3'b000, 1'b0, 2'b01);
        step(1);             chk("ext3_ch0",     3'b001, 1'b0, 2'b01);
        step(2);             chk("ext3_ch1",     3'b011, 1'b0, 2'b01);
        step(2);             chk("ext3_run",     3'b111, 1'b1, 2'b01);

        // Soft reset from RUN
        step(2);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;   chk("sw_trig",      3'b000, 1'b0, 2'b10);
        step(3);             chk("sw_hold",      3'b000, 1'b0, 2'b10);
        step(1);             chk("sw_ch0",       3'b001, 1'b0, 2'b10);
        step(2);             chk("sw_ch1",       3'b011, 1'b0, 2'b10);
        step(2);             chk("sw_run",       3'b111, 1'b1, 2'b10);

        // Soft reset in the middle of RELEASE restarts the full hold
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;   chk("mid_first",    3'b000, 1'b0, 2'b10);
        step(6);             chk("mid_at011",    3'b011, 1'b0, 2'b10);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;   chk("mid_trig",     3'b000, 1'b0, 2'b10);
        step(1);
        sw_rst_req = 1'b1;   // in HOLD: must not restart the count
        step(1);
        sw_rst_req = 1'b0;   chk("hold_sw_ign",  3'b000, 1'b0, 2'b10);
        step(1);             chk("mid_hold3",    3'b000, 1'b0, 2'b10);
        step(1);             chk("mid_ch0",      3'b001, 1'b0, 2'b10);
        step(4);             chk("mid_run",      3'b111, 1'b1, 2'b10);

        // Asynchronous rst override between edges during RELEASE
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(5);             chk("async_pre",    3'b001, 1'b0, 2'b10);
        #3;
        rst = 1'b0;
        #1;                  chk("async_ovr",    3'b000, 1'b0, 2'b00);
        #2;
        rst = 1'b1;
        step(2);             chk("async_t0",     3'b000, 1'b0, 2'b00);
        step(8);             chk("async_run",    3'b111, 1'b1, 2'b00);

        // Sustained external low keeps the hold counter at zero
        ext_rst_n = 1'b0;
        step(8);
        ext_rst_n = 1'b1;
        step(5);             chk("sustain_hold", 3'b000, 1'b0, 2'b01);
        step(1);             chk("sustain_ch0",  3'b001, 1'b0, 2'b01);
        step(4);             chk("sustain_run",  3'b111, 1'b1, 2'b01);

        // Simultaneous soft and external trigger records external cause
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(8);             chk("simul_pre",    3'b111, 1'b1, 2'b10);
        ext_rst_n = 1'b0;
        step(3);
        ext_rst_n = 1'b1;
        step(1);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;   chk("simul_trig",   3'b000, 1'b0, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 2: synchronizer depth on rst and ext_rst_n; legal >= 2.
REQ-002 SHALL have parameter CHANNELS, default 4: number of sequenced reset outputs; legal 1..16.
REQ-003 SHALL have parameter HOLD_CYCLES, default 8: minimum cycles all channels stay asserted; legal >= 1.
REQ-004 SHALL have parameter GAP_CYCLES, default 4: cycles between consecutive channel releases; legal >= 1.
REQ-005 SHALL have parameter FILTER_LEN, default 3: consecutive low samples needed to accept ext_rst_n; legal >= 1.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port ext_rst_n, input, 1: asynchronous external reset source, active-low, may glitch.
REQ-009 SHALL have port sw_rst_req, input, 1: synchronous single-cycle soft-reset request.
REQ-010 SHALL have port sync_rst_n, output, CHANNELS: per-channel reset, active-low, bit 0 released first.
REQ-011 SHALL have port rst_done, output, 1: high when every channel is released.
REQ-012 SHALL have port rst_cause, output, 2: last reset source; 00 power-on (rst), 01 external, 10 software.

Function
REQ-013 SHALL synchronize rst through a STAGES-deep chain: assertion asynchronous, deassertion after STAGES clk edges (internal por_n).
REQ-014 SHALL synchronize ext_rst_n through a STAGES-deep chain, then filter: trigger only after FILTER_LEN consecutive low synchronized samples; shorter low runs SHALL be ignored and reset the filter count.
REQ-015 SHALL implement FSM states HOLD, RELEASE, RUN.
REQ-016 HOLD: all sync_rst_n low, rst_done low; hold counter increments each cycle; at count HOLD_CYCLES SHALL enter RELEASE and deassert sync_rst_n[0] on that edge.
REQ-017 RELEASE: after each GAP_CYCLES cycles SHALL deassert the next channel in index order; on release of channel CHANNELS-1 SHALL enter RUN and raise rst_done on the same edge.
REQ-018 RUN: all sync_rst_n high, rst_done high, until a trigger.
REQ-019 A trigger (accepted ext filter or sw_rst_req) in RELEASE or RUN SHALL drive all sync_rst_n low and rst_done low on the next edge and enter HOLD with hold counter zero.
REQ-020 While the filtered external trigger stays active SHALL remain in HOLD with hold counter held at zero.
REQ-021 sw_rst_req in HOLD SHALL be ignored; sw_rst_req and ext trigger on the same cycle SHALL record cause 01.
REQ-022 rst_cause SHALL update on the edge a trigger is accepted and hold otherwise.
REQ-023 Counters SHALL be sized $clog2(max+1); no wrap-around in any legal configuration.
REQ-024 With CHANNELS=1 SHALL go HOLD->RUN directly, releasing bit 0 and raising rst_done together.

Reset
REQ-025 On rst low, asynchronously: sync_rst_n all 0, rst_done 0, rst_cause 00, FSM HOLD, all counters and synchronizer flops 0.
REQ-026 Release timing from rst rising: T0 = STAGES-th edge; channel k deasserts at edge T0+HOLD_CYCLES+k*GAP_CYCLES.
REQ-027 rst low mid-RELEASE or mid-RUN SHALL override all state immediately, without clock.

Structure
REQ-028 Shared package rst_seq_pkg SHALL hold FSM state encoding and rst_cause codes (CAUSE_POR, CAUSE_EXT, CAUSE_SW).
REQ-029 The STAGES-deep async-assert/sync-deassert chain SHALL be sub-module rst_sync_chain, instantiated twice (rst, ext_rst_n).
REQ-030 All outputs SHALL be driven directly from flops.

Verification (STAGES=2, CHANNELS=3, HOLD_CYCLES=4, GAP_CYCLES=2, FILTER_LEN=3)
REQ-031 Power-on: rst 0->1 -> sync_rst_n 000 until T0+4, then 001, 011 at T0+6, 111 with rst_done=1 at T0+8, rst_cause=00.
REQ-032 Glitch: ext_rst_n low 2 cycles in RUN -> no change, sync_rst_n stays 111; low 3 cycles -> 000 next edge, rst_cause=01, re-release 4/2/2 cycles after ext_rst_n filter clears.
REQ-033 Soft reset: sw_rst_req pulse in RUN -> sync_rst_n 000 next edge, rst_cause=10, sequence repeats as REQ-031 from that edge.
REQ-034 Trigger mid-RELEASE: sw_rst_req at sync_rst_n=011 -> 000 next edge, full HOLD_CYCLES re-counted.
REQ-035 Async override: rst low between clk edges during RELEASE -> outputs 000 before next edge; simultaneous sw_rst_req+ext trigger -> rst_cause=01.
